word_mem_responder: RTL
=======================

Name: word_mem_responder

Overview:
- Single-port word-addressed memory responder: the slave end of the mem_we / mem_addr / mem_write_data / mem_read_data bus driven by the team's memory-master blocks (e.g. the byte-rotation engine).
- Serves reads with one-cycle registered latency and writes on the clock edge.
- Adds a host preload port, a bulk-clear sequencer and access counters, so benches and top-levels can stage message buffers and check traffic.

Parameters:
- DEPTH, 1024, number of 32-bit words; legal addresses 0..DEPTH-1.
- OOB_DATA, 32'hDEAD_BEEF, read data returned for out-of-range addresses.

Ports:
- clk  in  1  single clock; the master's mem_clk is this same clock.
- reset_n  in  1  asynchronous, active-low reset.
- mem_we  in  1  1 = write, 0 = read; sampled every cycle while SERVE.
- mem_addr  in  16  word address.
- mem_write_data  in  32  write data.
- mem_read_data  out  32  registered read data.
- host_we  in  1  preload write strobe.
- host_addr  in  16  preload address.
- host_wdata  in  32  preload data.
- clear_req  in  1  pulse to start the bulk clear.
- busy  out  1  high while CLEAR is in progress.
- rd_count  out  16  bus reads serviced (saturating).
- wr_count  out  16  bus writes committed (saturating).
- err_oob  out  1  sticky out-of-range access flag.
- err_collide  out  1  sticky flag: host and bus wrote the same address in the same cycle.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: mem_read_data=0, busy=0, rd_count=0, wr_count=0, err_oob=0, err_collide=0.
  - State returns to SERVE.
  - Storage array is NOT reset; contents persist.
- State machine, two states:
  - SERVE → CLEAR on clear_req=1.
  - CLEAR → SERVE after the cycle that writes word DEPTH-1.
  - clear_req while already in CLEAR is ignored.
- SERVE, bus read (mem_we=0, addr<DEPTH): mem_read_data <= mem[addr] at the edge; the value is valid the cycle after the address is presented. rd_count +1.
- SERVE, bus write (mem_we=1, addr<DEPTH): mem[addr] <= mem_write_data at the edge. wr_count +1. mem_read_data holds its previous value.
- Out of range (addr>=DEPTH):
  - Read returns OOB_DATA and sets err_oob; rd_count still increments.
  - Write is dropped and sets err_oob; wr_count does not increment.
- Read and write address the same location in consecutive cycles: a read issued in the cycle after a write returns the new data.
- Host preload:
  - host_we=1 writes mem[host_addr] in any state except CLEAR.
  - host_addr>=DEPTH: write dropped, no flag raised.
- Simultaneous host_we and bus mem_we:
  - Different addresses: both commit.
  - Same address: the host write wins, the bus write is dropped, wr_count is not incremented, and err_collide is set.
- Bus read and host write to the same address in the same cycle: the read returns the old word.
- CLEAR:
  - busy=1 from the cycle after clear_req is sampled.
  - An internal index counts 0..DEPTH-1, writing one zero word per cycle.
  - busy falls in the cycle after the last zero write. Total busy duration = DEPTH cycles.
  - During CLEAR, bus and host writes are ignored with no flags raised.
  - During CLEAR, bus reads return 0 and do not count.
- Counters saturate at 16'hFFFF.
- Reset asserted mid-CLEAR: busy drops immediately and the array stays partially cleared.

Decomposition:
- Shared package mem_bus_pkg: state enum (SERVE, CLEAR), word_t (logic [31:0]), MEM_ADDR_W=16, OOB_DATA default constant.
- One natural sub-module: sat_counter16 (enable, saturating), instantiated for rd_count and wr_count.
- Storage array plus FSM stay in word_mem_responder.

Test Plan:
- Preload via host at addr 0..3 with 32'h11223344, 32'hAABBCCDD, 0, 32'h01020304; then bus read addr 2 → mem_read_data=0 one cycle after the address; rd_count=1.
- Bus write 32'hCAFEF00D to addr 5, then read addr 5 in the next cycle → 32'hCAFEF00D; wr_count=1.
- Drive the byte-rotation master against this block with a message at 0 and output at 16; after done, read addr 16 → 32'h22334411 (rotation of 32'h11223344).
- Bus read addr 16'h0400 with DEPTH=1024 → mem_read_data=32'hDEAD_BEEF and err_oob=1; err_oob stays 1 until reset.
- Host and bus both write addr 7 in the same cycle (host 32'h1, bus 32'h2) → mem[7]=32'h1, err_collide=1, wr_count unchanged.
- clear_req with DEPTH=16 → busy high for exactly 16 cycles; afterwards reads of 0..15 all return 0. Repeat with reset_n pulsed low at cycle 5 → busy=0 immediately and addr 10 keeps its old data.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the word-addressed memory bus.
package mem_bus_pkg;

    typedef enum logic {SERVE, CLEAR} state_t;

    typedef logic [31:0] word_t;

    localparam int    MEM_ADDR_W       = 16;
    localparam word_t OOB_DATA_DEFAULT = 32'hDEAD_BEEF;

    function automatic logic in_range(input logic [MEM_ADDR_W-1:0] addr, input int depth);
        return int'({16'h0, addr}) < depth;
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// sat_counter16: 16-bit enable counter that sticks at its maximum value.
module sat_counter16 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (en && count != 16'hFFFF)
            count <= count + 16'd1;
    end

endmodule

// File: rtl/word_mem_responder.sv
// word_mem_responder: single-port word memory slave with host preload, bulk clear and access counters.
module word_mem_responder
    import mem_bus_pkg::*;
#(
    parameter int    DEPTH    = 1024,
    parameter word_t OOB_DATA = OOB_DATA_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mem_we,
    input  logic [MEM_ADDR_W-1:0] mem_addr,
    input  word_t                 mem_write_data,
    output word_t                 mem_read_data,
    input  logic                  host_we,
    input  logic [MEM_ADDR_W-1:0] host_addr,
    input  word_t                 host_wdata,
    input  logic                  clear_req,
    output logic                  busy,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count,
    output logic                  err_oob,
    output logic                  err_collide
);

    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    state_t        state, state_nxt;
    word_t         mem [DEPTH];
    logic [AW-1:0] clr_idx;
    logic          serve, bus_ok, host_ok, bus_rd, bus_wr, host_wr, collide, clr_last;

    assign serve    = state == SERVE;
    assign busy     = state == CLEAR;
    assign bus_ok   = in_range(mem_addr, DEPTH);
    assign host_ok  = in_range(host_addr, DEPTH);
    assign clr_last = clr_idx == AW'(DEPTH - 1);
    // On a same-address double write the host owns the word and the bus write is discarded
    assign collide  = serve && mem_we && host_we && bus_ok && host_ok && mem_addr == host_addr;
    assign bus_rd   = serve && !mem_we;
    assign bus_wr   = serve && mem_we && bus_ok && !collide;
    assign host_wr  = serve && host_we && host_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= SERVE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        state_nxt = serve ? (clear_req ? CLEAR : SERVE) : (clr_last ? SERVE : CLEAR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            clr_idx <= '0;
        else if (busy)
            clr_idx <= clr_last ? '0 : clr_idx + 1'b1;
    end

    // Storage is deliberately not reset so preloaded contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (busy)
            mem[clr_idx] <= '0;
        if (bus_wr)
            mem[mem_addr[AW-1:0]] <= mem_write_data;
        if (host_wr)
            mem[host_addr[AW-1:0]] <= host_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            mem_read_data <= '0;
        else if (!mem_we)
            mem_read_data <= !serve ? '0 : bus_ok ? mem[mem_addr[AW-1:0]] : OOB_DATA;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_oob     <= 1'b0;
            err_collide <= 1'b0;
        end else begin
            err_oob     <= err_oob | (serve & ~bus_ok);
            err_collide <= err_collide | collide;
        end
    end

    sat_counter16 u_rd_count (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (bus_rd),
        .count   (rd_count)
    );

    sat_counter16 u_wr_count (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (bus_wr),
        .count   (wr_count)
    );

endmodule
